// File: rtl/if_fetch_stage_if.sv
// IF/ID producer-side bundle: run control, hazard/redirect inputs, debug loader
// port, and the fetched PC/instruction presented to the IF/ID register.
`timescale 1ns/1ps
interface if_fetch_stage_if #(
  parameter int NB = 32,
  parameter int AW = 8
);
  logic          i_start;
  logic          i_continuous;
  logic          i_step;
  logic          i_stall;
  logic          i_redirect;
  logic [NB-1:0] i_redirect_pc;
  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [NB-1:0] i_wr_data;
  logic [NB-1:0] o_pc;
  logic [NB-1:0] o_pc4;
  logic [NB-1:0] o_instruction;
  logic          o_halt;
  logic [1:0]    o_state;

  modport master (
    output i_start, i_continuous, i_step, i_stall, i_redirect, i_redirect_pc,
           i_wr_en, i_wr_addr, i_wr_data,
    input  o_pc, o_pc4, o_instruction, o_halt, o_state
  );

  modport slave (
    input  i_start, i_continuous, i_step, i_stall, i_redirect, i_redirect_pc,
           i_wr_en, i_wr_addr, i_wr_data,
    output o_pc, o_pc4, o_instruction, o_halt, o_state
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, debug-loaded word memory with
// zero-latency read, run/step/stall/redirect sequencing and HALT detection.
`timescale 1ns/1ps
module if_fetch_stage #(
  parameter int            NB         = 32,
  parameter int            IMEM_DEPTH = 256,
  parameter logic [NB-1:0] HALT_WORD  = 32'hFFFF_FFFF,
  localparam int           AW         = $clog2(IMEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  if_fetch_stage_if.slave   fetch
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [NB-1:0] pc_q, pc_d;
  logic          halt_q, halt_d;

  logic [NB-1:0] mem_q [IMEM_DEPTH];
  logic          in_range;
  logic [NB-1:0] rd_word;
  logic          adv;

  // Word index above the memory reads as NOP rather than aliasing.
  assign in_range = (pc_q[NB-1:AW+2] == '0);
  assign rd_word  = in_range ? mem_q[pc_q[AW+1:2]] : '0;
  assign adv      = fetch.i_continuous | fetch.i_step;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    halt_d  = halt_q;
    unique case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (fetch.i_start) state_d = S_RUN;
      end
      S_RUN: begin
        // Redirect wins over everything; its fetched word is wrong-path.
        if (fetch.i_redirect) begin
          pc_d = fetch.i_redirect_pc;
        end else if (fetch.i_stall || !adv) begin
          pc_d = pc_q;
        end else if (rd_word == HALT_WORD) begin
          state_d = S_HALTED;
          halt_d  = 1'b1;
        end else begin
          pc_d = pc_q + NB'(4);
        end
      end
      S_HALTED: begin
        pc_d = pc_q;
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        halt_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      halt_q  <= halt_d;
    end
  end

  // Contents deliberately survive reset so a loaded program can be rerun.
  always_ff @(posedge i_clk) begin
    if (!i_reset && state_q == S_IDLE && fetch.i_wr_en)
      mem_q[fetch.i_wr_addr] <= fetch.i_wr_data;
  end

  assign fetch.o_pc          = pc_q;
  assign fetch.o_pc4         = pc_q + NB'(4);
  assign fetch.o_instruction = rd_word;
  assign fetch.o_halt        = halt_q;
  assign fetch.o_state       = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a transaction-level model of the fetch
// rules is checked every cycle, plus literal expectations from the test plan.
`timescale 1ns/1ps
module tb_if_fetch_stage;
  localparam int NB    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_fetch_stage_if #(.NB(NB), .AW(AW)) bus ();

  if_fetch_stage #(.NB(NB), .IMEM_DEPTH(DEPTH), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .fetch   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: memory image, PC, mode (0 idle, 1 run, 2 halted), halt flag.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc   = 32'h0;
  int          m_mode = 0;
  bit          m_halt = 1'b0;
  bit          mem_ok = 1'b0;

  logic [31:0] prog [4];

  function automatic logic [31:0] m_fetch(input logic [31:0] pc);
    longint unsigned w;
    w = longint'(pc) / 4;
    if (w >= DEPTH) return 32'h0;
    return m_mem[int'(w)];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("model_pc", bus.o_pc, m_pc);
    chk("model_pc4", bus.o_pc4, m_pc + 32'd4);
    chk("model_halt", {31'd0, bus.o_halt}, {31'd0, m_halt});
    chk("model_state", {30'd0, bus.o_state}, 32'(m_mode));
    if (mem_ok) chk("model_instr", bus.o_instruction, m_fetch(m_pc));
  endtask

  // One clock: work out what the spec says happens at the edge, take the edge,
  // then compare the settled outputs against the model.
  task automatic tick();
    logic [31:0] npc;
    int          nmode;
    bit          nh;
    bit          do_wr;
    npc = m_pc; nmode = m_mode; nh = m_halt; do_wr = 1'b0;
    if (rst) begin
      npc = 0; nmode = 0; nh = 0;
    end else if (m_mode == 0) begin
      npc = 0;
      do_wr = bus.i_wr_en;
      if (bus.i_start) nmode = 1;
    end else if (m_mode == 1) begin
      if (bus.i_redirect) npc = bus.i_redirect_pc;
      else if (bus.i_stall) npc = m_pc;
      else if (!(bus.i_continuous || bus.i_step)) npc = m_pc;
      else if (m_fetch(m_pc) == 32'hFFFF_FFFF) begin nmode = 2; nh = 1; end
      else npc = m_pc + 32'd4;
    end
    if (do_wr) m_mem[bus.i_wr_addr] = bus.i_wr_data;
    @(posedge clk);
    m_pc = npc; m_mode = nmode; m_halt = nh;
    #2;
    compare_model();
  endtask

  initial begin
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003;
    prog[2] = 32'h0022_1820; prog[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    bus.i_start = 0; bus.i_continuous = 0; bus.i_step = 0; bus.i_stall = 0;
    bus.i_redirect = 0; bus.i_redirect_pc = 0; bus.i_wr_en = 0;
    bus.i_wr_addr = 0; bus.i_wr_data = 0;

    rst = 1; tick(); rst = 0;
    chk("reset_pc", bus.o_pc, 32'h0);
    chk("reset_state", {30'd0, bus.o_state}, 32'h0);
    chk("reset_halt", {31'd0, bus.o_halt}, 32'h0);

    // Load program; remaining words cleared so every fetch is defined.
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_wr_en = 1; bus.i_wr_addr = AW'(i);
      bus.i_wr_data = (i < 4) ? prog[i] : 32'h0;
      tick();
    end
    bus.i_wr_en = 0; mem_ok = 1;
    chk("load_word0", bus.o_instruction, 32'h2001_0005);

    // Continuous run to HALT.
    bus.i_continuous = 1; bus.i_start = 1; tick(); bus.i_start = 0;
    chk("run_state", {30'd0, bus.o_state}, 32'h1);
    chk("run_pc0", bus.o_pc, 32'h0);
    tick(); chk("run_pc4", bus.o_pc, 32'h4);
    tick(); chk("run_pc8", bus.o_pc, 32'h8);
    tick(); chk("run_pcC", bus.o_pc, 32'hC);
    chk("run_halt_pending", {31'd0, bus.o_halt}, 32'h0);
    tick(); chk("halt_pc", bus.o_pc, 32'hC);
    chk("halt_pc4", bus.o_pc4, 32'h10);
    chk("halt_flag", {31'd0, bus.o_halt}, 32'h1);
    chk("halt_state", {30'd0, bus.o_state}, 32'h2);

    // HALTED ignores everything but reset.
    bus.i_redirect = 1; bus.i_redirect_pc = 32'h40; bus.i_step = 1; bus.i_start = 1;
    bus.i_stall = 1; bus.i_wr_en = 1; bus.i_wr_addr = 0; bus.i_wr_data = 32'h0;
    tick();
    chk("halted_frozen_pc", bus.o_pc, 32'hC);
    bus.i_redirect = 0; bus.i_step = 0; bus.i_start = 0; bus.i_stall = 0; bus.i_wr_en = 0;

    rst = 1; tick(); rst = 0;
    chk("rst_halted_pc", bus.o_pc, 32'h0);
    chk("rst_halted_halt", {31'd0, bus.o_halt}, 32'h0);
    chk("rst_halted_state", {30'd0, bus.o_state}, 32'h0);
    chk("retained_word0", bus.o_instruction, 32'h2001_0005);

    // Single-step.
    bus.i_continuous = 0; bus.i_start = 1; tick(); bus.i_start = 0;
    repeat (5) tick();
    chk("step_idle_pc", bus.o_pc, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      bus.i_step = 1; tick(); bus.i_step = 0;
      chk("step_pc", bus.o_pc, 32'(4 * k));
      tick(); chk("step_hold_pc", bus.o_pc, 32'(4 * k));
    end
    bus.i_step = 1; bus.i_stall = 1; tick();
    bus.i_step = 0; bus.i_stall = 0; tick();
    chk("step_stall_not_queued", bus.o_pc, 32'hC);
    chk("step_no_halt", {31'd0, bus.o_halt}, 32'h0);

    // Stall during run.
    rst = 1; tick(); rst = 0;
    bus.i_start = 1; tick(); bus.i_start = 0;
    bus.i_step = 1; tick(); bus.i_step = 0;
    chk("stall_setup_pc", bus.o_pc, 32'h4);
    bus.i_continuous = 1; bus.i_stall = 1;
    repeat (3) begin
      tick();
      chk("stall_pc", bus.o_pc, 32'h4);
      chk("stall_instr", bus.o_instruction, 32'h2002_0003);
    end
    bus.i_stall = 0; tick();
    chk("stall_release_pc", bus.o_pc, 32'h8);

    // Redirect beats stall.
    bus.i_redirect = 1; bus.i_redirect_pc = 32'h40; bus.i_stall = 1; tick();
    chk("redir_stall_pc", bus.o_pc, 32'h40);
    bus.i_redirect = 0; bus.i_stall = 0; bus.i_continuous = 0; tick();

    // Redirect suppresses HALT detection on the wrong-path word.
    rst = 1; tick(); rst = 0;
    bus.i_wr_en = 1; bus.i_wr_addr = 2; bus.i_wr_data = 32'hFFFF_FFFF; tick(); bus.i_wr_en = 0;
    bus.i_start = 1; tick(); bus.i_start = 0;
    bus.i_step = 1; tick(); tick(); bus.i_step = 0;
    chk("halt_at_word2", bus.o_instruction, 32'hFFFF_FFFF);
    bus.i_continuous = 1; bus.i_redirect = 1; bus.i_redirect_pc = 32'h40; tick();
    bus.i_redirect = 0;
    chk("redir_halt_pc", bus.o_pc, 32'h40);
    chk("redir_halt_flag", {31'd0, bus.o_halt}, 32'h0);
    chk("redir_halt_state", {30'd0, bus.o_state}, 32'h1);

    // Writes during RUN are dropped.
    bus.i_wr_en = 1; bus.i_wr_addr = 0; bus.i_wr_data = 32'hDEAD_BEEF; tick(); bus.i_wr_en = 0;

    // Out-of-range fetch and PC wrap.
    bus.i_redirect = 1; bus.i_redirect_pc = 32'h400; tick(); bus.i_redirect = 0;
    chk("oor_pc", bus.o_pc, 32'h400);
    chk("oor_instr", bus.o_instruction, 32'h0);
    tick(); chk("oor_adv_pc", bus.o_pc, 32'h404);
    bus.i_redirect = 1; bus.i_redirect_pc = 32'hFFFF_FFFC; tick(); bus.i_redirect = 0;
    chk("wrap_pc4", bus.o_pc4, 32'h0);
    tick(); chk("wrap_pc", bus.o_pc, 32'h0);
    chk("run_write_ignored", bus.o_instruction, 32'h2001_0005);
    tick(); tick(); tick();
    chk("halt_word2_pc", bus.o_pc, 32'h8);
    chk("halt_word2_state", {30'd0, bus.o_state}, 32'h2);

    // Reset overrides start and loader write.
    rst = 1; bus.i_start = 1; bus.i_wr_en = 1; bus.i_wr_addr = 5; bus.i_wr_data = 32'h1234;
    tick();
    rst = 0; bus.i_start = 0; bus.i_wr_en = 0;
    chk("rst_override_state", {30'd0, bus.o_state}, 32'h0);

    // Unaligned redirect accepted as-is.
    bus.i_continuous = 0; bus.i_start = 1; tick(); bus.i_start = 0;
    bus.i_redirect = 1; bus.i_redirect_pc = 32'h42; tick(); bus.i_redirect = 0;
    chk("unaligned_pc", bus.o_pc, 32'h42);
    chk("unaligned_pc4", bus.o_pc4, 32'h46);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
